// File: rtl/avg_pool_pkg.sv
// Shared definitions for the average-pooling feeder.
//   state_t        : feeder FSM encoding (also exported for debug observation)
//   WINDOW_DEFAULT : elements per channel tile (7x7)
//   BF16_49        : bf16 encoding of 49.0, the divisor the pooling unit applies
package avg_pool_pkg;

  localparam int          WINDOW_DEFAULT = 49;
  localparam logic [15:0] BF16_49        = 16'h4244;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_WAIT_RES = 3'd3,
    ST_WRITE    = 3'd4,
    ST_FIN      = 3'd5
  } state_t;

endpackage

// File: rtl/avg_pool_feeder_if.sv
// Bus bundle between the feeder and its neighbours: activation SRAM read port,
// beat stream into the pooling unit, pooled result return, output buffer write.
// master : the feeder side.  slave : the SRAM / pooling unit / output buffer side.
//
// Handshake semantics: the stream has no backpressure. A beat exists in every
// cycle pool_valid_o is high; pool_last_o marks the final beat of a channel.
// rd_data_i must hold the word for the address presented with rd_en_o exactly
// one cycle later. pool_res_valid_i is a single-cycle strobe qualifying pool_res_i.
// wr_en_o is a single-cycle strobe qualifying wr_addr_o / wr_data_o.
interface avg_pool_feeder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_BITS  = 16
) ();

  logic                  rd_en_o;
  logic [ADDR_BITS-1:0]  rd_addr_o;
  logic [DATA_WIDTH-1:0] rd_data_i;
  logic                  pool_valid_o;
  logic                  pool_last_o;
  logic [DATA_WIDTH-1:0] pool_data_o;
  logic                  pool_res_valid_i;
  logic [DATA_WIDTH-1:0] pool_res_i;
  logic                  wr_en_o;
  logic [ADDR_BITS-1:0]  wr_addr_o;
  logic [DATA_WIDTH-1:0] wr_data_o;

  modport master (
    output rd_en_o, rd_addr_o,
    input  rd_data_i,
    output pool_valid_o, pool_last_o, pool_data_o,
    input  pool_res_valid_i, pool_res_i,
    output wr_en_o, wr_addr_o, wr_data_o
  );

  modport slave (
    input  rd_en_o, rd_addr_o,
    output rd_data_i,
    input  pool_valid_o, pool_last_o, pool_data_o,
    output pool_res_valid_i, pool_res_i,
    input  wr_en_o, wr_addr_o, wr_data_o
  );

endinterface

// File: rtl/avg_pool_addr_gen.sv
// Read-address generator for the feeder.
// Holds the current channel base, element counter k, channel index and the
// latched channel count.
//   load_i    : latch base_i / num_ch_i, clear k and channel index
//   step_i    : one element read issued this cycle (k advances, wraps at WINDOW-1)
//   advance_i : channel finished; base += WINDOW, channel index += 1
//   rd_addr_o : base + k (modulo 2^ADDR_BITS)
//   last_o    : k == WINDOW-1
//   ch_done_o : the current channel is the final one
//   ch_o      : current channel index
module avg_pool_addr_gen #(
  parameter int ADDR_BITS = 16,
  parameter int WINDOW    = 49,
  parameter int CH_BITS   = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [ADDR_BITS-1:0] base_i,
  input  logic [CH_BITS-1:0]   num_ch_i,
  input  logic                 step_i,
  input  logic                 advance_i,
  output logic [ADDR_BITS-1:0] rd_addr_o,
  output logic                 last_o,
  output logic                 ch_done_o,
  output logic [CH_BITS-1:0]   ch_o
);

  localparam int K_BITS = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  logic [ADDR_BITS-1:0] ch_base_q, ch_base_d;
  logic [K_BITS-1:0]    k_q, k_d;
  logic [CH_BITS-1:0]   ch_q, ch_d;
  logic [CH_BITS-1:0]   num_ch_q, num_ch_d;
  logic [CH_BITS:0]     ch_plus_one;

  assign last_o      = (k_q == K_BITS'(WINDOW - 1));
  assign rd_addr_o   = ch_base_q + ADDR_BITS'(k_q);
  assign ch_o        = ch_q;
  // One extra bit so the compare cannot overflow at the maximum channel count.
  assign ch_plus_one = {1'b0, ch_q} + {{CH_BITS{1'b0}}, 1'b1};
  assign ch_done_o   = (ch_plus_one == {1'b0, num_ch_q});

  always_comb begin
    ch_base_d = ch_base_q;
    k_d       = k_q;
    ch_d      = ch_q;
    num_ch_d  = num_ch_q;
    if (load_i) begin
      ch_base_d = base_i;
      k_d       = '0;
      ch_d      = '0;
      num_ch_d  = num_ch_i;
    end else begin
      if (step_i) begin
        k_d = last_o ? '0 : k_q + K_BITS'(1);
      end
      if (advance_i) begin
        // Stride by addition keeps the base walk multiplier-free.
        ch_base_d = ch_base_q + ADDR_BITS'(WINDOW);
        ch_d      = ch_q + CH_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ch_base_q <= '0;
      k_q       <= '0;
      ch_q      <= '0;
      num_ch_q  <= '0;
    end else begin
      ch_base_q <= ch_base_d;
      k_q       <= k_d;
      ch_q      <= ch_d;
      num_ch_q  <= num_ch_d;
    end
  end

endmodule

// File: rtl/avg_pool_feeder.sv
// Producer side of the average-pooling stream. For each channel it reads a
// WINDOW-element tile from the activation SRAM, streams it as gap-free beats
// into the pooling unit, waits for the averaged result, writes it to the output
// buffer at out_base + channel, and moves on until num_ch channels are done.
// Ports:
//   clk_i, rst_ni         : clock, synchronous active-low reset
//   start_i               : start pulse, honoured only in IDLE
//   in_base_i, out_base_i : read base of channel 0 / write address of channel 0
//   num_ch_i              : channel count, latched with start_i
//   bus_if                : SRAM read, beat stream, result return, output write
//   busy_o                : high while working (not in IDLE or FIN)
//   done_o                : one-cycle pulse after the final write
//   state_o               : current FSM state for observation
module avg_pool_feeder
  import avg_pool_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_BITS  = 16,
  parameter int WINDOW     = WINDOW_DEFAULT,
  parameter int CH_BITS    = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [ADDR_BITS-1:0] in_base_i,
  input  logic [ADDR_BITS-1:0] out_base_i,
  input  logic [CH_BITS-1:0]   num_ch_i,
  avg_pool_feeder_if.master    bus_if,
  output logic                 busy_o,
  output logic                 done_o,
  output state_t               state_o
);

  state_t                state_q, state_d;
  logic [ADDR_BITS-1:0]  out_base_q;
  logic [DATA_WIDTH-1:0] res_q;
  logic                  pool_valid_q;
  logic                  pool_last_q;

  logic                  load;
  logic                  capture;
  logic                  advance;
  logic                  issue;
  logic                  writing;
  logic [ADDR_BITS-1:0]  gen_addr;
  logic                  gen_last;
  logic                  gen_ch_done;
  logic [CH_BITS-1:0]    gen_ch;

  avg_pool_addr_gen #(
    .ADDR_BITS (ADDR_BITS),
    .WINDOW    (WINDOW),
    .CH_BITS   (CH_BITS)
  ) u_addr_gen (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (load),
    .base_i    (in_base_i),
    .num_ch_i  (num_ch_i),
    .step_i    (issue),
    .advance_i (advance),
    .rd_addr_o (gen_addr),
    .last_o    (gen_last),
    .ch_done_o (gen_ch_done),
    .ch_o      (gen_ch)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    capture = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          load    = 1'b1;
          state_d = (num_ch_i == '0) ? ST_FIN : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (gen_last) state_d = ST_DRAIN;
      end
      // Lets the final beat of the tile leave the pipeline register.
      ST_DRAIN: state_d = ST_WAIT_RES;
      ST_WAIT_RES: begin
        if (bus_if.pool_res_valid_i) begin
          capture = 1'b1;
          state_d = ST_WRITE;
        end
      end
      // WRITE sits between the result strobe and the next ISSUE, giving the
      // pooling unit a cycle to return to idle before the next first beat.
      ST_WRITE: begin
        advance = 1'b1;
        state_d = gen_ch_done ? ST_FIN : ST_ISSUE;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign issue   = (state_q == ST_ISSUE);
  assign writing = (state_q == ST_WRITE);

  // Address/data outputs are forced to zero when not qualified so that the
  // bus is quiet outside its strobes.
  assign bus_if.rd_en_o      = issue;
  assign bus_if.rd_addr_o    = issue ? gen_addr : '0;
  assign bus_if.pool_valid_o = pool_valid_q;
  assign bus_if.pool_last_o  = pool_last_q;
  // The SRAM already registers the word, so it lines up with the delayed valid.
  assign bus_if.pool_data_o  = pool_valid_q ? bus_if.rd_data_i : '0;
  assign bus_if.wr_en_o      = writing;
  assign bus_if.wr_addr_o    = writing ? (out_base_q + ADDR_BITS'(gen_ch)) : '0;
  assign bus_if.wr_data_o    = writing ? res_q : '0;

  assign busy_o  = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign done_o  = (state_q == ST_FIN);
  assign state_o = state_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      out_base_q   <= '0;
      res_q        <= '0;
      pool_valid_q <= 1'b0;
      pool_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pool_valid_q <= issue;
      pool_last_q  <= issue && gen_last;
      if (load)    out_base_q <= out_base_i;
      if (capture) res_q      <= bus_if.pool_res_i;
    end
  end

endmodule

// File: tb/tb_avg_pool_feeder.sv
module tb_avg_pool_feeder;
  import avg_pool_pkg::*;

  localparam int RES_DELAY = 10;

  logic        clk;
  logic        rst_ni;
  logic        start_i;
  logic [15:0] in_base_i;
  logic [15:0] out_base_i;
  logic [11:0] num_ch_i;
  logic        busy_o;
  logic        done_o;
  state_t      state_o;

  avg_pool_feeder_if #(.DATA_WIDTH(16), .ADDR_BITS(16)) pif ();

  avg_pool_feeder dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .in_base_i  (in_base_i),
    .out_base_i (out_base_i),
    .num_ch_i   (num_ch_i),
    .bus_if     (pif),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .state_o    (state_o)
  );

  // ---------------- clock / reset / cycle counter ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- SRAM model: word = address - 0x0100 ----------------
  always @(posedge clk) begin
    if (pif.rd_en_o) pif.rd_data_i <= pif.rd_addr_o - 16'h0100;
    else             pif.rd_data_i <= 16'hBEEF;
  end

  // ---------------- pooling unit model ----------------
  int   pend     = -1;
  int   res_cnt  = 0;
  logic spur_req = 1'b0;
  initial begin
    pif.pool_res_valid_i = 1'b0;
    pif.pool_res_i       = 16'h1234;
  end
  always @(negedge clk) begin
    if (!rst_ni) begin
      pend = -1;
      pif.pool_res_valid_i = 1'b0;
    end else begin
      if (spur_req) begin
        pif.pool_res_valid_i = 1'b1;
        pif.pool_res_i       = 16'hDEAD;
        spur_req             = 1'b0;
      end else if (pend == 0) begin
        pif.pool_res_valid_i = 1'b1;
        pif.pool_res_i       = 16'h3F80 + 16'(res_cnt);
        res_cnt++;
        pend = -1;
      end else begin
        pif.pool_res_valid_i = 1'b0;
        pif.pool_res_i       = 16'h1234;
        if (pend > 0) pend--;
      end
      if (pif.pool_valid_o && pif.pool_last_o) pend = RES_DELAY;
    end
  end

  // ---------------- monitor logs ----------------
  logic [15:0] rd_addr_log[$];
  logic [15:0] beat_data_log[$];
  logic        beat_last_log[$];
  int          beat_cyc_log[$];
  logic [15:0] wr_addr_log[$];
  logic [15:0] wr_data_log[$];
  int first_rd_cyc, done_cyc, done_cnt, busy_cnt, overlap_cnt, stray_last;

  always @(negedge clk) begin
    if (pif.rd_en_o) begin
      if (rd_addr_log.size() == 0) first_rd_cyc = cyc;
      rd_addr_log.push_back(pif.rd_addr_o);
    end
    if (pif.pool_valid_o) begin
      beat_data_log.push_back(pif.pool_data_o);
      beat_last_log.push_back(pif.pool_last_o);
      beat_cyc_log.push_back(cyc);
    end
    if (pif.pool_last_o && !pif.pool_valid_o) stray_last++;
    if (pif.wr_en_o) begin
      wr_addr_log.push_back(pif.wr_addr_o);
      wr_data_log.push_back(pif.wr_data_o);
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy_o) busy_cnt++;
    if (busy_o && done_o) overlap_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_addr_log.delete();
    beat_data_log.delete();
    beat_last_log.delete();
    beat_cyc_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    first_rd_cyc = -1;
    done_cyc     = -1;
    done_cnt     = 0;
    busy_cnt     = 0;
    overlap_cnt  = 0;
    stray_last   = 0;
    res_cnt      = 0;
  endtask

  task automatic do_start(input logic [15:0] ib, input logic [15:0] ob,
                          input logic [11:0] n, output int s_cyc);
    in_base_i  = ib;
    out_base_i = ob;
    num_ch_i   = n;
    start_i    = 1'b1;
    s_cyc      = cyc;
    step();
    start_i    = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    n_checks++;
    if (done_cnt == 0) begin
      n_fail++;
      $display("FAIL %s_timeout: done_o not seen within %0d cycles", name, budget);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [15:0] act;
    rst_ni = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 11; i++) begin
      case (i)
        0:  act = 16'(pif.rd_en_o);
        1:  act = pif.rd_addr_o;
        2:  act = 16'(pif.pool_valid_o);
        3:  act = 16'(pif.pool_last_o);
        4:  act = pif.pool_data_o;
        5:  act = 16'(pif.wr_en_o);
        6:  act = pif.wr_addr_o;
        7:  act = pif.wr_data_o;
        8:  act = 16'(busy_o);
        9:  act = 16'(done_o);
        default: act = 16'(state_o);
      endcase
      n_checks++;
      if (act !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_out%0d: got %h expected 0000", i, act);
      end
    end
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_single();
    int s;
    clear_logs();
    do_start(16'h0100, 16'h0200, 12'd1, s);
    wait_done(500, "single");
    n_checks++;
    if (rd_addr_log.size() != 49 || beat_data_log.size() != 49) begin
      n_fail++;
      $display("FAIL single_count: reads %0d beats %0d expected 49/49",
               rd_addr_log.size(), beat_data_log.size());
    end
    for (int k = 0; k < 49 && k < beat_data_log.size() && k < rd_addr_log.size(); k++) begin
      n_checks++;
      if (rd_addr_log[k] !== 16'h0100 + 16'(k) || beat_data_log[k] !== 16'(k) ||
          beat_last_log[k] !== (k == 48)) begin
        n_fail++;
        $display("FAIL single_beat%0d: addr %h data %h last %b expected %h %h %b", k,
                 rd_addr_log[k], beat_data_log[k], beat_last_log[k],
                 16'h0100 + 16'(k), 16'(k), (k == 48));
      end
    end
    n_checks++;
    if (first_rd_cyc != s + 1 || beat_cyc_log.size() != 49 ||
        beat_cyc_log[0] != s + 2 || beat_cyc_log[48] != s + 50) begin
      n_fail++;
      $display("FAIL single_timing: first rd %0d first beat %0d last beat %0d expected %0d %0d %0d",
               first_rd_cyc - s, beat_cyc_log.size() > 0 ? beat_cyc_log[0] - s : -1,
               beat_cyc_log.size() > 48 ? beat_cyc_log[48] - s : -1, 1, 2, 50);
    end
    n_checks++;
    if (wr_addr_log.size() != 1 || wr_addr_log[0] !== 16'h0200 || wr_data_log[0] !== 16'h3F80) begin
      n_fail++;
      $display("FAIL single_write: count %0d addr %h data %h expected 1 0200 3f80",
               wr_addr_log.size(), wr_addr_log.size() > 0 ? wr_addr_log[0] : 16'hxxxx,
               wr_data_log.size() > 0 ? wr_data_log[0] : 16'hxxxx);
    end
    n_checks++;
    if (done_cnt != 1 || overlap_cnt != 0 || stray_last != 0) begin
      n_fail++;
      $display("FAIL single_done: done %0d overlap %0d stray %0d expected 1 0 0",
               done_cnt, overlap_cnt, stray_last);
    end
    step();
  endtask

  task automatic test_multi();
    int s;
    int idx;
    clear_logs();
    do_start(16'h0000, 16'h0400, 12'd3, s);
    wait_done(1000, "multi");
    n_checks++;
    if (rd_addr_log.size() != 147 || beat_data_log.size() != 147) begin
      n_fail++;
      $display("FAIL multi_count: reads %0d beats %0d expected 147/147",
               rd_addr_log.size(), beat_data_log.size());
    end
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 49; k++) begin
        idx = c * 49 + k;
        if (idx >= rd_addr_log.size() || idx >= beat_data_log.size()) break;
        n_checks++;
        if (rd_addr_log[idx] !== 16'(idx) || beat_data_log[idx] !== 16'(idx) - 16'h0100 ||
            beat_last_log[idx] !== (k == 48) ||
            (k > 0 && beat_cyc_log[idx] != beat_cyc_log[idx-1] + 1)) begin
          n_fail++;
          $display("FAIL multi_beat c%0d k%0d: addr %h data %h last %b expected %h %h %b gap-free",
                   c, k, rd_addr_log[idx], beat_data_log[idx], beat_last_log[idx],
                   16'(idx), 16'(idx) - 16'h0100, (k == 48));
        end
      end
    end
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (c >= wr_addr_log.size() || wr_addr_log[c] !== 16'h0400 + 16'(c) ||
          wr_data_log[c] !== 16'h3F80 + 16'(c)) begin
        n_fail++;
        $display("FAIL multi_write%0d: count %0d addr %h data %h expected %h %h", c,
                 wr_addr_log.size(), c < wr_addr_log.size() ? wr_addr_log[c] : 16'hxxxx,
                 c < wr_data_log.size() ? wr_data_log[c] : 16'hxxxx,
                 16'h0400 + 16'(c), 16'h3F80 + 16'(c));
      end
    end
    n_checks++;
    if (wr_addr_log.size() != 3 || done_cnt != 1 || overlap_cnt != 0) begin
      n_fail++;
      $display("FAIL multi_done: writes %0d done %0d overlap %0d expected 3 1 0",
               wr_addr_log.size(), done_cnt, overlap_cnt);
    end
    step();
  endtask

  task automatic test_zero();
    int s;
    clear_logs();
    do_start(16'h0100, 16'h0300, 12'd0, s);
    repeat (20) step();
    n_checks++;
    if (done_cnt != 1 || done_cyc != s + 1) begin
      n_fail++;
      $display("FAIL zero_done: pulses %0d at %0d expected 1 at 1", done_cnt, done_cyc - s);
    end
    n_checks++;
    if (rd_addr_log.size() != 0 || wr_addr_log.size() != 0 ||
        beat_data_log.size() != 0 || busy_cnt != 0) begin
      n_fail++;
      $display("FAIL zero_quiet: reads %0d writes %0d beats %0d busy %0d expected 0 0 0 0",
               rd_addr_log.size(), wr_addr_log.size(), beat_data_log.size(), busy_cnt);
    end
  endtask

  task automatic test_wrap();
    int s;
    logic [15:0] exp_a;
    clear_logs();
    do_start(16'hFFF0, 16'h0500, 12'd1, s);
    wait_done(500, "wrap");
    n_checks++;
    if (rd_addr_log.size() != 49) begin
      n_fail++;
      $display("FAIL wrap_count: reads %0d expected 49", rd_addr_log.size());
    end
    for (int k = 0; k < 49 && k < rd_addr_log.size() && k < beat_data_log.size(); k++) begin
      exp_a = 16'hFFF0 + 16'(k);
      n_checks++;
      if (rd_addr_log[k] !== exp_a || beat_data_log[k] !== exp_a - 16'h0100) begin
        n_fail++;
        $display("FAIL wrap_beat%0d: addr %h data %h expected %h %h", k,
                 rd_addr_log[k], beat_data_log[k], exp_a, exp_a - 16'h0100);
      end
    end
    n_checks++;
    if (rd_addr_log.size() > 16 && (rd_addr_log[15] !== 16'hFFFF || rd_addr_log[16] !== 16'h0000)) begin
      n_fail++;
      $display("FAIL wrap_edge: k15 %h k16 %h expected ffff 0000", rd_addr_log[15], rd_addr_log[16]);
    end
    n_checks++;
    if (wr_addr_log.size() != 1 || wr_addr_log[0] !== 16'h0500) begin
      n_fail++;
      $display("FAIL wrap_write: count %0d expected 1 at 0500", wr_addr_log.size());
    end
    step();
  endtask

  task automatic test_reset_mid();
    int s;
    int n = 0;
    int rd_sz, bt_sz, wr_sz;
    clear_logs();
    do_start(16'h0000, 16'h0600, 12'd2, s);
    while (beat_data_log.size() < 70 && n < 500) begin
      step();
      n++;
    end
    n_checks++;
    if (beat_data_log.size() != 70) begin
      n_fail++;
      $display("FAIL rstmid_reach: beats %0d expected 70", beat_data_log.size());
    end
    rst_ni = 1'b0;
    step();
    n_checks++;
    if ({pif.rd_en_o, pif.pool_valid_o, pif.pool_last_o, pif.wr_en_o, busy_o, done_o} !== 6'b0 ||
        pif.rd_addr_o !== 16'h0 || pif.pool_data_o !== 16'h0 || state_o !== ST_IDLE) begin
      n_fail++;
      $display("FAIL rstmid_outs: rd %b v %b l %b wr %b busy %b done %b addr %h data %h expected all 0",
               pif.rd_en_o, pif.pool_valid_o, pif.pool_last_o, pif.wr_en_o, busy_o, done_o,
               pif.rd_addr_o, pif.pool_data_o);
    end
    rst_ni = 1'b1;
    rd_sz = rd_addr_log.size();
    bt_sz = beat_data_log.size();
    wr_sz = wr_addr_log.size();
    repeat (80) step();
    n_checks++;
    if (rd_addr_log.size() != rd_sz || beat_data_log.size() != bt_sz ||
        wr_addr_log.size() != wr_sz || done_cnt != 0) begin
      n_fail++;
      $display("FAIL rstmid_abort: activity after reset reads +%0d beats +%0d writes +%0d done %0d",
               rd_addr_log.size() - rd_sz, beat_data_log.size() - bt_sz,
               wr_addr_log.size() - wr_sz, done_cnt);
    end
    clear_logs();
    do_start(16'h0100, 16'h0700, 12'd1, s);
    wait_done(500, "rstmid_rerun");
    n_checks++;
    if (beat_data_log.size() != 49 || beat_data_log[0] !== 16'h0000 ||
        beat_data_log[48] !== 16'd48 || beat_last_log[48] !== 1'b1 ||
        wr_addr_log.size() != 1 || wr_addr_log[0] !== 16'h0700 || wr_data_log[0] !== 16'h3F80) begin
      n_fail++;
      $display("FAIL rstmid_rerun: beats %0d writes %0d expected 49 beats 0..48 and 1 write 0700/3f80",
               beat_data_log.size(), wr_addr_log.size());
    end
    step();
  endtask

  task automatic test_ignore();
    int s;
    int n = 0;
    clear_logs();
    do_start(16'h0100, 16'h0800, 12'd2, s);
    while (rd_addr_log.size() < 20 && n < 200) begin
      if (rd_addr_log.size() == 10 && !start_i) begin
        // Change every launch input and pulse start while the feeder is busy.
        in_base_i  = 16'h7000;
        out_base_i = 16'h7700;
        num_ch_i   = 12'd5;
        start_i    = 1'b1;
        step();
        start_i    = 1'b0;
      end else begin
        step();
      end
      n++;
    end
    spur_req = 1'b1;
    wait_done(1000, "ignore");
    repeat (30) step();
    n_checks++;
    if (rd_addr_log.size() != 98 || rd_addr_log[49] !== 16'h0131 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL ignore_reads: reads %0d done %0d expected 98 reads, ch1 base 0131, 1 done",
               rd_addr_log.size(), done_cnt);
    end
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if (c >= wr_addr_log.size() || wr_addr_log[c] !== 16'h0800 + 16'(c) ||
          wr_data_log[c] !== 16'h3F80 + 16'(c)) begin
        n_fail++;
        $display("FAIL ignore_write%0d: count %0d addr %h data %h expected %h %h", c,
                 wr_addr_log.size(), c < wr_addr_log.size() ? wr_addr_log[c] : 16'hxxxx,
                 c < wr_data_log.size() ? wr_data_log[c] : 16'hxxxx,
                 16'h0800 + 16'(c), 16'h3F80 + 16'(c));
      end
    end
    n_checks++;
    if (wr_addr_log.size() != 2) begin
      n_fail++;
      $display("FAIL ignore_wcount: writes %0d expected 2", wr_addr_log.size());
    end
  endtask

  initial begin
    rst_ni     = 1'b0;
    start_i    = 1'b0;
    in_base_i  = '0;
    out_base_i = '0;
    num_ch_i   = '0;
    clear_logs();
    test_reset();
    test_single();
    test_multi();
    test_zero();
    test_wrap();
    test_reset_mid();
    test_ignore();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
